// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and the colour selector encoding
// used by the board pixel generator and its raster counter.
package vga_pkg;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    SEL_FONDO  = 2'b00,
    SEL_LINEAS = 2'b10
  } sel_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters for 640x480@60 plus the raw (undelayed) sync and
// blank decode of the current position.
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce_i,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       h_last_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       blank_raw_o
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_V  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_V  = 10'(V_ACT);
  localparam logic [9:0] HS_START = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACT + V_FP + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce_i) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o    = hcount_q;
  assign vcount_o    = vcount_q;
  assign h_last_o    = (hcount_q == H_LAST);
  // Sync pulses are active-low.
  assign hsync_raw_o = !((hcount_q >= HS_START) && (hcount_q < HS_END));
  assign vsync_raw_o = !((vcount_q >= VS_START) && (vcount_q < VS_END));
  assign blank_raw_o = !((hcount_q < H_ACT_V) && (vcount_q < V_ACT_V));

endmodule

// File: rtl/board_pixel_gen.sv
// Board-grid pixel classifier: raster timing, grid line/background selector,
// and sync/blank delayed to line up with the downstream registered colour mux.
module board_pixel_gen
  import vga_pkg::*;
#(
  parameter int CELL_SIZE = 150,
  parameter int LINE_W    = 4,
  parameter int N_CELLS   = 3,
  parameter int BOARD_X0  = 93,
  parameter int BOARD_Y0  = 13,
  parameter int ALIGN_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [1:0] selector,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start
);

  localparam int COLW = $clog2(N_CELLS + 1);

  // Cell counters are preloaded one pixel early, so the board must not start at 0.
  if ((LINE_W < 1) || (LINE_W >= CELL_SIZE) || (N_CELLS < 1) ||
      (BOARD_X0 < 1) || (BOARD_Y0 < 1) || (ALIGN_DLY < 0) ||
      (BOARD_X0 + N_CELLS * CELL_SIZE + LINE_W > H_ACT) ||
      (BOARD_Y0 + N_CELLS * CELL_SIZE + LINE_W > V_ACT)) begin : g_bad_cfg
    $error("board_pixel_gen: board geometry out of range");
  end

  localparam logic [9:0]      X_PRE     = 10'(BOARD_X0 - 1);
  localparam logic [9:0]      Y_PRE     = 10'(BOARD_Y0 - 1);
  localparam logic [9:0]      CELL_LAST = 10'(CELL_SIZE - 1);
  localparam logic [9:0]      LW_V      = 10'(LINE_W);
  localparam logic [9:0]      LW_LAST   = 10'(LINE_W - 1);
  localparam logic [COLW-1:0] N_SAT     = COLW'(N_CELLS);

  logic       h_last;
  logic       hsync_raw, vsync_raw, blank_raw;

  vga_sync_counter u_sync (
    .clk        (clk),
    .rst        (rst),
    .pix_ce_i   (pix_ce),
    .hcount_o   (hcount),
    .vcount_o   (vcount),
    .h_last_o   (h_last),
    .hsync_raw_o(hsync_raw),
    .vsync_raw_o(vsync_raw),
    .blank_raw_o(blank_raw)
  );

  logic [9:0]      cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic [COLW-1:0] col_q, col_d, row_q, row_d;
  logic            in_x_q, in_x_d, in_y_q, in_y_d;

  // in_x/in_y mean "inside the board box"; cell_x/cell_y are the offsets mod CELL_SIZE.
  always_comb begin
    cell_x_d = cell_x_q;
    col_d    = col_q;
    in_x_d   = in_x_q;
    if (pix_ce) begin
      if (hcount == X_PRE) begin
        cell_x_d = '0;
        col_d    = '0;
        in_x_d   = 1'b1;
      end else if (in_x_q) begin
        if ((col_q == N_SAT) && (cell_x_q == LW_LAST)) begin
          in_x_d = 1'b0;
        end else if (cell_x_q == CELL_LAST) begin
          cell_x_d = '0;
          if (col_q != N_SAT) col_d = col_q + 1'b1;
        end else begin
          cell_x_d = cell_x_q + 10'd1;
        end
      end
    end
  end

  always_comb begin
    cell_y_d = cell_y_q;
    row_d    = row_q;
    in_y_d   = in_y_q;
    if (pix_ce && h_last) begin
      if (vcount == Y_PRE) begin
        cell_y_d = '0;
        row_d    = '0;
        in_y_d   = 1'b1;
      end else if (in_y_q) begin
        if ((row_q == N_SAT) && (cell_y_q == LW_LAST)) begin
          in_y_d = 1'b0;
        end else if (cell_y_q == CELL_LAST) begin
          cell_y_d = '0;
          if (row_q != N_SAT) row_d = row_q + 1'b1;
        end else begin
          cell_y_d = cell_y_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_x_q <= '0;
      col_q    <= '0;
      in_x_q   <= 1'b0;
      cell_y_q <= '0;
      row_q    <= '0;
      in_y_q   <= 1'b0;
    end else begin
      cell_x_q <= cell_x_d;
      col_q    <= col_d;
      in_x_q   <= in_x_d;
      cell_y_q <= cell_y_d;
      row_q    <= row_d;
      in_y_q   <= in_y_d;
    end
  end

  sel_t sel_d, sel_q;
  logic on_line, fs_d;
  logic fs_q, hs1_q, vs1_q, bl1_q;

  always_comb begin
    on_line = in_x_q && in_y_q && ((cell_x_q < LW_V) || (cell_y_q < LW_V));
    sel_d   = (!blank_raw && on_line) ? SEL_LINEAS : SEL_FONDO;
    fs_d    = (hcount == 10'd0) && (vcount == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_FONDO;
      fs_q  <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      bl1_q <= 1'b1;
    end else if (pix_ce) begin
      sel_q <= sel_d;
      fs_q  <= fs_d;
      hs1_q <= hsync_raw;
      vs1_q <= vsync_raw;
      bl1_q <= blank_raw;
    end
  end

  assign selector    = sel_q;
  assign frame_start = fs_q;

  if (ALIGN_DLY == 0) begin : g_no_dly
    assign hsync = hs1_q;
    assign vsync = vs1_q;
    assign blank = bl1_q;
  end else begin : g_dly
    logic [ALIGN_DLY-1:0] hs_dl_q, vs_dl_q, bl_dl_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        hs_dl_q <= '1;
        vs_dl_q <= '1;
        bl_dl_q <= '1;
      end else if (pix_ce) begin
        hs_dl_q[0] <= hs1_q;
        vs_dl_q[0] <= vs1_q;
        bl_dl_q[0] <= bl1_q;
        for (int i = 1; i < ALIGN_DLY; i++) begin
          hs_dl_q[i] <= hs_dl_q[i-1];
          vs_dl_q[i] <= vs_dl_q[i-1];
          bl_dl_q[i] <= bl_dl_q[i-1];
        end
      end
    end

    assign hsync = hs_dl_q[ALIGN_DLY-1];
    assign vsync = vs_dl_q[ALIGN_DLY-1];
    assign blank = bl_dl_q[ALIGN_DLY-1];
  end

endmodule

// File: tb/tb_board_pixel_gen.sv
// Bench for board_pixel_gen: a raster-position model with a short position
// history predicts every output after every clock edge.
module tb_board_pixel_gen;

  localparam int X0   = 93;
  localparam int Y0   = 13;
  localparam int CELL = 150;
  localparam int LW   = 4;
  localparam int N    = 3;
  localparam int DLY  = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] hcount, vcount;
  logic [1:0] selector;
  logic       hsync, vsync, blank, frame_start;

  board_pixel_gen #(
    .CELL_SIZE(CELL), .LINE_W(LW), .N_CELLS(N),
    .BOARD_X0(X0), .BOARD_Y0(Y0), .ALIGN_DLY(DLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .hcount     (hcount),
    .vcount     (vcount),
    .selector   (selector),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;

  // model: current raster position and the positions seen on earlier enabled edges
  int mx = 0, my = 0;
  int hist_x[$], hist_y[$];

  int hs_low = 0, cnt14 = 0, cnt30 = 0, fs_cnt = 0;

  function automatic logic [1:0] exp_sel(int x, int y);
    bit box, line;
    if (x < 0) return 2'b00;
    if (x >= 640 || y >= 480) return 2'b00;
    box  = (x >= X0) && (x <= X0 + N * CELL + LW - 1) &&
           (y >= Y0) && (y <= Y0 + N * CELL + LW - 1);
    if (!box) return 2'b00;
    line = ((x - X0) % CELL < LW) || ((y - Y0) % CELL < LW);
    return line ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0;
    my = 0;
    hist_x.delete();
    hist_y.delete();
    for (int i = 0; i <= DLY; i++) begin
      hist_x.push_back(-1);
      hist_y.push_back(-1);
    end
  endtask

  // driver: one clock edge with the given inputs, then model update and full compare
  task automatic step(input logic r, input logic ce);
    int sx, sy;
    logic e_hs, e_vs, e_bl, e_fs;
    rst = r;
    pix_ce = ce;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (ce) begin
      hist_x.push_front(mx);
      hist_y.push_front(my);
      void'(hist_x.pop_back());
      void'(hist_y.pop_back());
      mx++;
      if (mx == 800) begin
        mx = 0;
        my = (my + 1) % 525;
      end
    end
    #1;
    e_fs = (hist_x[0] == 0) && (hist_y[0] == 0);
    sx = hist_x[DLY];
    sy = hist_y[DLY];
    if (sx < 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1;
    end else begin
      e_hs = !(sx >= 656 && sx < 752);
      e_vs = !(sy >= 490 && sy < 492);
      e_bl = !(sx < 640 && sy < 480);
    end
    chk("hcount", 32'(hcount), 32'(mx));
    chk("vcount", 32'(vcount), 32'(my));
    chk("selector", 32'(selector), 32'(exp_sel(hist_x[0], hist_y[0])));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("blank", 32'(blank), 32'(e_bl));
    if (!r && ce) begin
      if (hist_y[0] == 14 && selector == 2'b10) cnt14++;
      if (hist_y[0] == 30 && selector == 2'b10) cnt30++;
    end
  endtask

  initial begin
    model_reset();

    // reset held three edges, once with pix_ce low to show reset dominates
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // continuous enable: first frame lines 0..32
    for (int k = 1; k <= 26000; k++) begin
      step(1'b0, 1'b1);
      if (k == 1) chk("hcount_after_first_edge", 32'(hcount), 32'd1);
      if (k <= 8000 && hsync == 1'b0) hs_low++;
      if (frame_start) fs_cnt++;
    end
    chk("hsync_low_in_10_lines", 32'(hs_low), 32'd960);
    chk("row14_line_pixels", 32'(cnt14), 32'd454);
    chk("row30_line_pixels", 32'(cnt30), 32'd16);
    chk("frame_start_pulses", 32'(fs_cnt), 32'd1);

    // 1-of-2 enable, entered mid-line
    for (int k = 0; k < 1600; k++) step(1'b0, (k % 2) == 0);

    // random enable
    for (int k = 0; k < 16000; k++) step(1'b0, 1'($urandom_range(0, 1)));

    // run to hcount=300 (bounded), then mid-line reset
    for (int k = 0; k < 800 && mx != 300; k++) step(1'b0, 1'b1);
    chk("reached_h300", 32'(hcount), 32'd300);
    step(1'b1, 1'b1);
    chk("midline_reset_hcount", 32'(hcount), 32'd0);
    chk("midline_reset_hsync", 32'(hsync), 32'd1);
    for (int k = 0; k < 2000; k++) step(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
